dma_prio_arb: RTL and testbench

- Parametrised successor to the fixed 4-channel DMA priority logic.
- Arbitrates NCH asynchronous DMA request lines, runs the HRQ/HLDA bus handshake with the CPU, and issues one-hot DACK to the winning channel.
- Adds per-channel masking, run-time selectable fixed or rotating priority, and a configurable DACK polarity.
- Sits between the peripheral request pins and the timing-control/datapath blocks, which signal end of service.

---
 rtl/dma_prio_arb.sv | 141 ++++++++++++++
 tb/tb_dma_prio_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_prio_arb.sv
`default_nettype none
// ============================================================================
// dma_prio_arb : NCH-channel DMA request arbiter with HRQ/HLDA bus handshake
// Revision     : 1.0
// ============================================================================
module dma_prio_arb #(
  parameter int NCH           = 4,
  parameter int SYNC_STAGES   = 2,
  parameter bit DACK_ACT_HIGH = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NCH-1:0]         DREQ,
  input  logic [NCH-1:0]         MASK,
  input  logic                   ROT_PRIO,
  input  logic                   HLDA,
  input  logic                   XFER_DONE,
  output logic                   HRQ,
  output logic [NCH-1:0]         DACK,
  output logic                   ACT_VALID,
  output logic [$clog2(NCH)-1:0] ACT_CH
);

  localparam int             c_cw        = $clog2(NCH);
  localparam logic [NCH-1:0] c_dack_idle = {NCH{~DACK_ACT_HIGH}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]                  w_pend;
  state_t                          state_q;
  logic                            rot_q;
  logic [c_cw-1:0]                 ptr_q;
  logic [c_cw-1:0]                 act_ch_q;
  logic                            hrq_q;
  logic                            valid_q;
  logic [NCH-1:0]                  dack_q;
  logic [c_cw-1:0]                 w_base;
  logic [c_cw-1:0]                 w_win;
  logic [c_cw:0]                   w_idx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], DREQ};
    end
  end

  assign w_pend = sync_q[SYNC_STAGES-1] & ~MASK;

  // ptr_q holds the last-serviced channel; rotating search begins just after it.
  assign w_base = rot_q ? ((ptr_q == c_cw'(NCH-1)) ? '0 : ptr_q + 1'b1) : '0;

  // Walk the search order backwards so the earliest requesting channel wins.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      w_idx = {1'b0, w_base} + (c_cw+1)'(k);
      if (w_idx >= (c_cw+1)'(NCH)) begin
        w_idx = w_idx - (c_cw+1)'(NCH);
      end
      if (w_pend[w_idx[c_cw-1:0]]) begin
        w_win = w_idx[c_cw-1:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      rot_q    <= 1'b0;
      ptr_q    <= c_cw'(NCH-1);
      hrq_q    <= 1'b0;
      dack_q   <= c_dack_idle;
      valid_q  <= 1'b0;
      act_ch_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|w_pend) begin
            state_q <= S_REQ;
            hrq_q   <= 1'b1;
            rot_q   <= ROT_PRIO;
          end
        end
        S_REQ: begin
          if (HLDA) begin
            if (|w_pend) begin
              state_q  <= S_GRANT;
              dack_q   <= c_dack_idle ^ (NCH'(1) << w_win);
              valid_q  <= 1'b1;
              act_ch_q <= w_win;
            end else begin
              state_q <= S_RELEASE;
              hrq_q   <= 1'b0;
            end
          end
        end
        S_GRANT: begin
          // Bus revocation takes precedence over a coincident end of service.
          if (!HLDA) begin
            state_q  <= S_IDLE;
            hrq_q    <= 1'b0;
            dack_q   <= c_dack_idle;
            valid_q  <= 1'b0;
            act_ch_q <= '0;
          end else if (XFER_DONE) begin
            state_q  <= S_RELEASE;
            hrq_q    <= 1'b0;
            dack_q   <= c_dack_idle;
            valid_q  <= 1'b0;
            act_ch_q <= '0;
            if (rot_q) begin
              ptr_q <= act_ch_q;
            end
          end
        end
        S_RELEASE: begin
          if (!HLDA) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign HRQ       = hrq_q;
  assign DACK      = dack_q;
  assign ACT_VALID = valid_q;
  assign ACT_CH    = act_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_prio_arb.sv
`default_nettype none
// Bench for dma_prio_arb: 4-channel active-high instance against a behavioural
// model, plus an 8-channel active-low instance for asynchronous reset.
module tb_dma_prio_arb;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET;
  logic [3:0] DREQ, MASK;
  logic       ROT_PRIO, HLDA, XFER_DONE;
  logic       HRQ;
  logic [3:0] DACK;
  logic       ACT_VALID;
  logic [1:0] ACT_CH;

  logic       RESET2;
  logic [7:0] DREQ2, MASK2, DACK2;
  logic       ROT2, HLDA2, XFER2, HRQ2, VALID2;
  logic [2:0] CH2;

  int checks   = 0;
  int failures = 0;

  dma_prio_arb #(.NCH(4), .SYNC_STAGES(2), .DACK_ACT_HIGH(1'b1)) u_dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .MASK(MASK), .ROT_PRIO(ROT_PRIO),
    .HLDA(HLDA), .XFER_DONE(XFER_DONE), .HRQ(HRQ), .DACK(DACK),
    .ACT_VALID(ACT_VALID), .ACT_CH(ACT_CH)
  );

  dma_prio_arb #(.NCH(8), .SYNC_STAGES(2), .DACK_ACT_HIGH(1'b0)) u_dut8 (
    .CLK(CLK), .RESET(RESET2), .DREQ(DREQ2), .MASK(MASK2), .ROT_PRIO(ROT2),
    .HLDA(HLDA2), .XFER_DONE(XFER2), .HRQ(HRQ2), .DACK(DACK2),
    .ACT_VALID(VALID2), .ACT_CH(CH2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // CPU side: HLDA follows HRQ two cycles late unless the bench overrides it.
  bit         hlda_force     = 1'b0;
  bit         hlda_force_val = 1'b0;
  logic [1:0] hrq_hist       = 2'b00;
  always @(negedge CLK) begin
    hrq_hist = {hrq_hist[0], HRQ};
    HLDA     = hlda_force ? hlda_force_val : hrq_hist[1];
  end

  // Behavioural model: phase 0 idle, 1 requesting, 2 granted, 3 releasing.
  int         m_ph   = 0;
  int         m_ch   = -1;
  int         m_last = 3;
  bit         m_rot  = 1'b0;
  bit         m_hrq  = 1'b0;
  logic [3:0] m_sync [2];
  logic [3:0] m_pend;
  logic [3:0] m_dack;

  function automatic int pick(input logic [3:0] p, input bit rot, input int last);
    int start;
    start = rot ? (last + 1) % 4 : 0;
    for (int k = 0; k < 4; k++) begin
      if (p[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  initial begin
    m_sync[0] = '0;
    m_sync[1] = '0;
    forever begin
      @(posedge CLK);
      if (RESET !== 1'b0) begin
        m_ph = 0; m_ch = -1; m_last = 3; m_rot = 1'b0; m_hrq = 1'b0;
        m_sync[0] = '0; m_sync[1] = '0;
      end else begin
        m_pend = m_sync[1] & ~MASK;
        case (m_ph)
          0: if (m_pend != 0) begin m_ph = 1; m_hrq = 1'b1; m_rot = ROT_PRIO; end
          1: if (HLDA) begin
               if (m_pend != 0) begin m_ph = 2; m_ch = pick(m_pend, m_rot, m_last); end
               else begin m_ph = 3; m_hrq = 1'b0; end
             end
          2: if (!HLDA) begin m_ph = 0; m_hrq = 1'b0; m_ch = -1; end
             else if (XFER_DONE) begin
               m_ph = 3; m_hrq = 1'b0;
               if (m_rot) m_last = m_ch;
               m_ch = -1;
             end
          default: if (!HLDA) m_ph = 0;
        endcase
        m_sync[1] = m_sync[0];
        m_sync[0] = DREQ;
      end
      #1;
      m_dack = '0;
      if (m_ch >= 0) m_dack[m_ch] = 1'b1;
      chk("model_hrq", HRQ, m_hrq);
      chk("model_dack", DACK, m_dack);
      chk("model_valid", ACT_VALID, m_ch >= 0);
      chk("model_act_ch", ACT_CH, (m_ch < 0) ? 0 : m_ch);
    end
  end

  task automatic wait_grant(output int ch);
    ch = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (ACT_VALID === 1'b1) begin
        ch = ACT_CH;
        return;
      end
    end
  endtask

  task automatic finish_service();
    XFER_DONE = 1'b1;
    @(negedge CLK);
    XFER_DONE = 1'b0;
  endtask

  int ch;
  int n_valid, n_hrq;
  bit seen;
  int exp_rot [5] = '{0, 1, 2, 3, 0};

  initial begin
    RESET = 1'b1; DREQ = '0; MASK = '0; ROT_PRIO = 1'b0; HLDA = 1'b0; XFER_DONE = 1'b0;
    RESET2 = 1'b1; DREQ2 = '0; MASK2 = '0; ROT2 = 1'b0; HLDA2 = 1'b0; XFER2 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_hrq", HRQ, 0);
    chk("rst_dack", DACK, 4'h0);
    chk("rst_valid", ACT_VALID, 0);
    chk("rst_act_ch", ACT_CH, 0);

    // Basic service and HRQ latency through the synchroniser.
    RESET = 1'b0;
    @(negedge CLK);
    DREQ = 4'b0001;
    @(posedge CLK); @(posedge CLK); #1;
    chk("t1_hrq_edge2", HRQ, 0);
    @(posedge CLK); #1;
    chk("t1_hrq_edge3", HRQ, 1);
    wait_grant(ch);
    chk("t1_ch", ch, 0);
    chk("t1_dack", DACK, 4'b0001);
    DREQ = 4'b0000;
    XFER_DONE = 1'b1;
    @(posedge CLK); #1;
    chk("t1_dack_off", DACK, 4'h0);
    chk("t1_hrq_off", HRQ, 0);
    @(negedge CLK);
    XFER_DONE = 1'b0;
    repeat (6) @(negedge CLK);

    // Fixed priority, then masking.
    DREQ = 4'b1010;
    for (int s = 0; s < 3; s++) begin
      wait_grant(ch);
      chk("t2_fixed_ch1", ch, 1);
      finish_service();
    end
    MASK = 4'b0010;
    wait_grant(ch);
    chk("t2_masked_ch3", ch, 3);
    finish_service();
    DREQ = '0; MASK = '0;
    repeat (8) @(negedge CLK);

    // Rotating priority from a fresh pointer.
    RESET = 1'b1;
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0; ROT_PRIO = 1'b1; DREQ = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_grant(ch);
      chk("t3_rot_order", ch, exp_rot[s]);
      finish_service();
    end
    DREQ = '0;
    repeat (8) @(negedge CLK);

    // Request withdrawn before HLDA: no grant, pointer untouched (still ch0).
    DREQ = 4'b0100;
    @(negedge CLK);
    DREQ = 4'b0000;
    n_valid = 0; n_hrq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ACT_VALID === 1'b1) n_valid++;
      if (HRQ === 1'b1) n_hrq++;
    end
    chk("t4_no_grant", n_valid, 0);
    chk("t4_hrq_seen", n_hrq > 0, 1);
    chk("t4_hrq_low", HRQ, 0);
    DREQ = 4'b1111;
    wait_grant(ch);
    chk("t4_ptr_kept", ch, 1);
    finish_service();

    // Bus revoked together with XFER_DONE: no pointer update (stays ch1).
    DREQ = 4'b0100;
    wait_grant(ch);
    chk("t5_ch2", ch, 2);
    hlda_force_val = 1'b0; hlda_force = 1'b1; HLDA = 1'b0;
    XFER_DONE = 1'b1; DREQ = 4'b1111;
    @(posedge CLK); #1;
    chk("t5_dack_off", DACK, 4'h0);
    chk("t5_hrq_off", HRQ, 0);
    @(negedge CLK);
    XFER_DONE = 1'b0;
    repeat (4) @(negedge CLK);
    hlda_force = 1'b0;
    wait_grant(ch);
    chk("t5_old_ptr", ch, 2);
    finish_service();
    DREQ = '0;
    repeat (8) @(negedge CLK);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RESET = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) DREQ = 4'($urandom);
      if ($urandom_range(0, 31) == 0) MASK = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 15) == 0) ROT_PRIO = 1'($urandom);
      XFER_DONE = ($urandom_range(0, 5) == 0);
      if (hlda_force) begin
        if ($urandom_range(0, 3) == 0) hlda_force = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        hlda_force_val = 1'b0; hlda_force = 1'b1; HLDA = 1'b0;
      end
    end
    RESET = 1'b0; XFER_DONE = 1'b0; hlda_force = 1'b0;

    // 8-channel active-low instance: reset value and asynchronous reset mid-grant.
    @(negedge CLK);
    chk("t6_rst_dack", DACK2, 8'hFF);
    chk("t6_rst_hrq", HRQ2, 0);
    RESET2 = 1'b0;
    DREQ2 = 8'h20;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (HRQ2 === 1'b1) seen = 1'b1;
    end
    chk("t6_hrq_up", seen, 1);
    HLDA2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (VALID2 === 1'b1) seen = 1'b1;
    end
    chk("t6_granted", seen, 1);
    chk("t6_ch5", CH2, 5);
    chk("t6_dack_low", DACK2, 8'hDF);
    #2 RESET2 = 1'b1;
    #1;
    chk("t6_async_dack", DACK2, 8'hFF);
    chk("t6_async_hrq", HRQ2, 0);
    chk("t6_async_valid", VALID2, 0);
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
